// File: rtl/step_sequencer.sv
// step_sequencer: micro-step address/enable generator for the 4-to-16 strobe decoder; optional IRQ entry via SEQ_IRQ_EN
module step_sequencer #(
  parameter logic [3:0] MAX_STEP = 4'd11,
  parameter logic [3:0] IRQ_BASE = 4'd12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  input  logic       last_step,
  input  logic       halt_req,
  input  logic       irq,
  output logic [3:0] a,
  output logic [1:0] g,
  output logic       busy,
  output logic       done,
  output logic       irq_ack
);
  typedef enum logic [1:0] {IDLE, RUN, IRQ, HALT} state_t;
  state_t     state, state_n;
  logic [3:0] a_n;
  logic       ack_n, irq_go, bnd, active_n;
`ifdef SEQ_IRQ_EN
  assign irq_go = irq;
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_go = 1'b0;
`endif
  assign bnd = !stall && (last_step || a == MAX_STEP);
  assign active_n = state_n == RUN || state_n == IRQ;
  // next state and step address; halt outranks interrupt entry at a boundary
  always_comb begin
    state_n = state;
    a_n = a;
    ack_n = 1'b0;
    case (state)
      IDLE: begin
        a_n = 4'd0;
        state_n = start ? RUN : IDLE;
      end
      RUN: begin
        if (bnd) begin
          state_n = halt_req ? HALT : irq_go ? IRQ : RUN;
          a_n = (!halt_req && irq_go) ? IRQ_BASE : 4'd0;
          ack_n = !halt_req && irq_go;
        end else if (!stall) begin
          a_n = a + 4'd1;
        end
      end
      IRQ: begin
        if (!stall) begin
          state_n = (a == 4'hF) ? RUN : IRQ;
          a_n = (a == 4'hF) ? 4'd0 : a + 4'd1;
        end
      end
      HALT: begin
        state_n = IDLE;
        a_n = 4'd0;
      end
      default: begin
        state_n = IDLE;
        a_n = 4'd0;
      end
    endcase
  end
  // registered state and outputs, derived from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a <= 4'd0;
      g <= 2'b11;
      busy <= 1'b0;
      done <= 1'b0;
      irq_ack <= 1'b0;
    end else begin
      state <= state_n;
      a <= a_n;
      g <= active_n ? 2'b00 : 2'b11;
      busy <= active_n;
      done <= state_n == HALT;
      irq_ack <= ack_n;
    end
  end
endmodule
